// File: rtl/aes_mode_engine.sv
// AES block-mode streaming engine: packs DW-bit beats into 128-bit blocks, applies
// ECB/CBC/CTR chaining around an external cipher core, and unpacks results into beats.
module aes_mode_engine #(
   parameter int DW    = 32,
   parameter int LEN_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [127:0]     key_i,
   input  logic [127:0]     iv_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [DW-1:0]    in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DW-1:0]    out_data_o,
   output logic             core_ld_o,
   output logic [127:0]     core_key_o,
   output logic [127:0]     core_text_o,
   input  logic             core_done_i,
   input  logic [127:0]     core_text_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [LEN_W-1:0] blk_cnt_o,
   output logic [2:0]       state_o
);

   localparam int BEATS = 128 / DW;
   localparam int BC_W  = $clog2(BEATS) + 1;
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

   localparam logic [1:0] M_ECB = 2'd0;
   localparam logic [1:0] M_CBC = 2'd1;
   localparam logic [1:0] M_CTR = 2'd2;
   localparam logic [1:0] M_RSV = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_CIPHER = 3'd2,
      S_WAIT   = 3'd3,
      S_DRAIN  = 3'd4,
      S_FIN    = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       mode_q;
   logic [LEN_W-1:0] len_q;
   logic [127:0]     key_q;
   logic [127:0]     chain_q;
   logic [127:0]     blk_q;
   logic [127:0]     res_q;
   logic [BC_W-1:0]  beat_q;
   logic [LEN_W-1:0] blk_cnt_q;

   logic             in_hs, out_hs, last_in, last_out;
   logic [LEN_W-1:0] blk_next;

   // Handshakes: a beat moves when valid and ready are both high at a clk_i edge;
   // ready/valid on our side never look at the partner's valid/ready.
   assign in_hs    = (state_q == S_LOAD) && in_valid_i;
   assign out_hs   = (state_q == S_DRAIN) && out_ready_i;
   assign last_in  = in_hs && (beat_q == LAST_BEAT);
   assign last_out = out_hs && (beat_q == LAST_BEAT);
   assign blk_next = blk_cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_i && (mode_i != M_RSV))
                      state_d = (len_i == '0) ? S_FIN : S_LOAD;
         S_LOAD:   if (last_in) state_d = S_CIPHER;
         S_CIPHER: state_d = S_WAIT;
         S_WAIT:   if (core_done_i) state_d = S_DRAIN;
         S_DRAIN:  if (last_out) state_d = (blk_next < len_q) ? S_LOAD : S_FIN;
         S_FIN:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      core_text_o = '0;
      if ((state_q == S_CIPHER) || (state_q == S_WAIT)) begin
         case (mode_q)
            M_ECB:   core_text_o = blk_q;
            M_CBC:   core_text_o = blk_q ^ chain_q;
            default: core_text_o = chain_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         mode_q    <= '0;
         len_q     <= '0;
         key_q     <= '0;
         chain_q   <= '0;
         blk_q     <= '0;
         res_q     <= '0;
         beat_q    <= '0;
         blk_cnt_q <= '0;
      end else if (clear_i) begin
         // Job configuration survives a soft clear; datapath and progress do not.
         state_q   <= S_IDLE;
         chain_q   <= '0;
         blk_q     <= '0;
         res_q     <= '0;
         beat_q    <= '0;
         blk_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (start_i) begin
               mode_q    <= mode_i;
               len_q     <= len_i;
               key_q     <= key_i;
               chain_q   <= iv_i;
               blk_cnt_q <= '0;
            end
            S_LOAD: if (in_hs) begin
               blk_q  <= (blk_q << DW) | 128'(in_data_i);
               beat_q <= last_in ? '0 : beat_q + 1'b1;
            end
            S_WAIT: if (core_done_i) begin
               res_q <= (mode_q == M_CTR) ? (core_text_i ^ blk_q) : core_text_i;
               if (mode_q == M_CBC)      chain_q <= core_text_i;
               else if (mode_q == M_CTR) chain_q <= chain_q + 128'd1;
            end
            S_DRAIN: if (out_hs) begin
               res_q  <= res_q << DW;
               beat_q <= last_out ? '0 : beat_q + 1'b1;
               if (last_out) blk_cnt_q <= blk_next;
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o  = (state_q == S_LOAD);
   assign out_valid_o = (state_q == S_DRAIN);
   assign out_data_o  = res_q[127 -: DW];
   assign core_ld_o   = (state_q == S_CIPHER);
   assign core_key_o  = key_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_FIN);
   assign blk_cnt_o   = blk_cnt_q;
   assign state_o     = state_q;

endmodule
